// File: rtl/counter_bank.sv
// Bank of CH independent prescaled event counters with wrap/saturate modes,
// sticky per-channel overflow and a registered single-channel read port.
module counter_bank #(
  parameter  int CH      = 4,
  parameter  int WIDTH   = 64,
  parameter  int PW      = 8,
  parameter  int DEF_DIV = 1,
  localparam int CW      = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic                  En,
  input  logic [CW-1:0]         Sel,
  input  logic                  Clr,
  input  logic                  Cfg_we,
  input  logic [PW-1:0]         Cfg_div,
  input  logic                  Cfg_sat,
  input  logic [CW-1:0]         Rd_sel,
  output logic [WIDTH-1:0]      Rd_count,
  output logic                  Rd_ovf,
  output logic [CH*WIDTH-1:0]   Count_all,
  output logic [CH-1:0]         Ovf
);

  logic [WIDTH-1:0] count_r [CH];
  logic [PW-1:0]    pre_r   [CH];
  logic [PW-1:0]    div_r   [CH];
  logic [CH-1:0]    sat_r;
  logic [CH-1:0]    ovf_r;

  logic [CH-1:0]    sel_hit_s;
  logic [PW-1:0]    last_pre_s [CH];
  logic [WIDTH-1:0] rd_count_s;
  logic             rd_ovf_s;

  // Channel decode and terminal prescale value (a divisor of 0 behaves as 1).
  always_comb begin
    sel_hit_s = '0;
    for (int i = 0; i < CH; i++) begin
      sel_hit_s[i] = (Sel == CW'(i));
      if (div_r[i] == {PW{1'b0}}) begin
        last_pre_s[i] = {PW{1'b0}};
      end else begin
        last_pre_s[i] = div_r[i] - {{(PW-1){1'b0}}, 1'b1};
      end
    end
  end

  // Read-port mux; an out-of-range Rd_sel matches no channel and yields zero.
  always_comb begin
    rd_count_s = {WIDTH{1'b0}};
    rd_ovf_s   = 1'b0;
    for (int i = 0; i < CH; i++) begin
      if (Rd_sel == CW'(i)) begin
        rd_count_s = count_r[i];
        rd_ovf_s   = ovf_r[i];
      end else begin
        rd_count_s = rd_count_s;
        rd_ovf_s   = rd_ovf_s;
      end
    end
  end

  // Per-channel state update with priority Clr > Cfg_we > En.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < CH; i++) begin
        count_r[i] <= {WIDTH{1'b0}};
        pre_r[i]   <= {PW{1'b0}};
        div_r[i]   <= PW'(DEF_DIV);
      end
      sat_r <= {CH{1'b0}};
      ovf_r <= {CH{1'b0}};
    end else begin
      for (int i = 0; i < CH; i++) begin
        if (sel_hit_s[i] && Clr) begin
          count_r[i] <= {WIDTH{1'b0}};
          pre_r[i]   <= {PW{1'b0}};
          ovf_r[i]   <= 1'b0;
        end else if (sel_hit_s[i] && Cfg_we) begin
          div_r[i] <= Cfg_div;
          sat_r[i] <= Cfg_sat;
          pre_r[i] <= {PW{1'b0}};
        end else if (sel_hit_s[i] && En) begin
          if (pre_r[i] == last_pre_s[i]) begin
            pre_r[i] <= {PW{1'b0}};
            if (count_r[i] == {WIDTH{1'b1}}) begin
              ovf_r[i] <= 1'b1;
              if (!sat_r[i]) begin
                count_r[i] <= {WIDTH{1'b0}};
              end
            end else begin
              count_r[i] <= count_r[i] + {{(WIDTH-1){1'b0}}, 1'b1};
            end
          end else begin
            pre_r[i] <= pre_r[i] + {{(PW-1){1'b0}}, 1'b1};
          end
        end
      end
    end
  end

  // Registered read port: captures the selected channel as held before the edge.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      Rd_count <= {WIDTH{1'b0}};
      Rd_ovf   <= 1'b0;
    end else begin
      Rd_count <= rd_count_s;
      Rd_ovf   <= rd_ovf_s;
    end
  end

  for (genvar g = 0; g < CH; g++) begin : g_out
    assign Count_all[g*WIDTH +: WIDTH] = count_r[g];
  end
  assign Ovf = ovf_r;

endmodule

// File: tb/tb_counter_bank.sv
// Directed bench for counter_bank: a vector table for prescale/priority/select
// behaviour plus hand sequences for wrap, saturate and mid-cycle reset.
module tb_counter_bank;
  localparam int CH = 3;
  localparam int WIDTH = 8;
  localparam int PW = 8;
  localparam int CW = 2;

  logic              Clk = 1'b0;
  logic              Reset_n;
  logic              En, Clr, Cfg_we, Cfg_sat;
  logic [CW-1:0]     Sel, Rd_sel;
  logic [PW-1:0]     Cfg_div;
  logic [WIDTH-1:0]  Rd_count;
  logic              Rd_ovf;
  logic [CH*WIDTH-1:0] Count_all;
  logic [CH-1:0]     Ovf;

  int compared = 0;
  int mismatched = 0;

  counter_bank #(.CH(CH), .WIDTH(WIDTH), .PW(PW), .DEF_DIV(1)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .En(En), .Sel(Sel), .Clr(Clr),
    .Cfg_we(Cfg_we), .Cfg_div(Cfg_div), .Cfg_sat(Cfg_sat), .Rd_sel(Rd_sel),
    .Rd_count(Rd_count), .Rd_ovf(Rd_ovf), .Count_all(Count_all), .Ovf(Ovf)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic       en, clr, we, sat;
    logic [1:0] sel, rd;
    logic [7:0] div;
    logic [7:0] c0, c1, c2;
    logic [2:0] ovf;
    logic [7:0] rdc;
  } vec_t;

  vec_t tv[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic en, input logic [1:0] sel, input logic clr,
                       input logic we, input logic [7:0] div, input logic sat,
                       input logic [1:0] rd);
    En = en; Sel = sel; Clr = clr; Cfg_we = we; Cfg_div = div; Cfg_sat = sat; Rd_sel = rd;
  endtask

  task automatic cycle();
    @(posedge Clk);
    #1;
  endtask

  task automatic add(input logic en, input logic [1:0] sel, input logic clr,
                     input logic we, input logic [7:0] div, input logic sat,
                     input logic [1:0] rd, input logic [7:0] c0, input logic [7:0] c1,
                     input logic [7:0] c2, input logic [7:0] rdc);
    vec_t v;
    v.en = en; v.sel = sel; v.clr = clr; v.we = we; v.div = div; v.sat = sat; v.rd = rd;
    v.c0 = c0; v.c1 = c1; v.c2 = c2; v.ovf = 3'b000; v.rdc = rdc;
    tv.push_back(v);
  endtask

  initial begin
    Reset_n = 1'b0;
    drive(1'b0, 2'd0, 1'b0, 1'b0, 8'd0, 1'b0, 2'd0);
    #3;
    chk("reset_count_all", 64'(Count_all), 64'd0);
    chk("reset_ovf", 64'(Ovf), 64'd0);
    chk("reset_rd_count", 64'(Rd_count), 64'd0);
    chk("reset_rd_ovf", 64'(Rd_ovf), 64'd0);
    @(negedge Clk);
    Reset_n = 1'b1;

    // en sel clr we div sat rd | c0 c1 c2 rdc
    add(1'b0, 2'd1, 1'b0, 1'b1, 8'd4, 1'b0, 2'd1, 8'd0, 8'd0, 8'd0, 8'd0);
    add(1'b1, 2'd1, 1'b0, 1'b0, 8'd0, 1'b0, 2'd1, 8'd0, 8'd0, 8'd0, 8'd0);
    add(1'b1, 2'd1, 1'b0, 1'b0, 8'd0, 1'b0, 2'd1, 8'd0, 8'd0, 8'd0, 8'd0);
    add(1'b1, 2'd1, 1'b0, 1'b0, 8'd0, 1'b0, 2'd1, 8'd0, 8'd0, 8'd0, 8'd0);
    add(1'b1, 2'd1, 1'b0, 1'b0, 8'd0, 1'b0, 2'd1, 8'd0, 8'd1, 8'd0, 8'd0);
    add(1'b1, 2'd1, 1'b0, 1'b0, 8'd0, 1'b0, 2'd1, 8'd0, 8'd1, 8'd0, 8'd1);
    add(1'b1, 2'd1, 1'b0, 1'b0, 8'd0, 1'b0, 2'd1, 8'd0, 8'd1, 8'd0, 8'd1);
    add(1'b1, 2'd1, 1'b0, 1'b0, 8'd0, 1'b0, 2'd1, 8'd0, 8'd1, 8'd0, 8'd1);
    add(1'b1, 2'd1, 1'b0, 1'b0, 8'd0, 1'b0, 2'd1, 8'd0, 8'd2, 8'd0, 8'd1);
    // pre1 is back at 0: three more events hold, the fourth steps
    add(1'b1, 2'd1, 1'b0, 1'b0, 8'd0, 1'b0, 2'd1, 8'd0, 8'd2, 8'd0, 8'd2);
    add(1'b1, 2'd1, 1'b0, 1'b0, 8'd0, 1'b0, 2'd1, 8'd0, 8'd2, 8'd0, 8'd2);
    add(1'b1, 2'd1, 1'b0, 1'b0, 8'd0, 1'b0, 2'd0, 8'd0, 8'd2, 8'd0, 8'd0);
    add(1'b1, 2'd1, 1'b0, 1'b0, 8'd0, 1'b0, 2'd1, 8'd0, 8'd3, 8'd0, 8'd2);
    add(1'b0, 2'd1, 1'b0, 1'b0, 8'd0, 1'b0, 2'd1, 8'd0, 8'd3, 8'd0, 8'd3);
    // Clr + Cfg_we + En together: clear only, divisor stays 4
    add(1'b1, 2'd1, 1'b1, 1'b1, 8'd2, 1'b1, 2'd1, 8'd0, 8'd0, 8'd0, 8'd3);
    add(1'b1, 2'd1, 1'b0, 1'b0, 8'd0, 1'b0, 2'd1, 8'd0, 8'd0, 8'd0, 8'd0);
    add(1'b1, 2'd1, 1'b0, 1'b0, 8'd0, 1'b0, 2'd1, 8'd0, 8'd0, 8'd0, 8'd0);
    add(1'b1, 2'd1, 1'b0, 1'b0, 8'd0, 1'b0, 2'd1, 8'd0, 8'd0, 8'd0, 8'd0);
    add(1'b1, 2'd1, 1'b0, 1'b0, 8'd0, 1'b0, 2'd1, 8'd0, 8'd1, 8'd0, 8'd0);
    add(1'b0, 2'd1, 1'b0, 1'b0, 8'd0, 1'b0, 2'd1, 8'd0, 8'd1, 8'd0, 8'd1);
    // Cfg_we + En: config taken, event dropped; then div=0 steps every event
    add(1'b1, 2'd1, 1'b0, 1'b1, 8'd0, 1'b0, 2'd1, 8'd0, 8'd1, 8'd0, 8'd1);
    add(1'b1, 2'd1, 1'b0, 1'b0, 8'd0, 1'b0, 2'd1, 8'd0, 8'd2, 8'd0, 8'd1);
    add(1'b1, 2'd1, 1'b0, 1'b0, 8'd0, 1'b0, 2'd1, 8'd0, 8'd3, 8'd0, 8'd2);
    add(1'b1, 2'd1, 1'b0, 1'b0, 8'd0, 1'b0, 2'd1, 8'd0, 8'd4, 8'd0, 8'd3);
    // Sel out of range: no effect
    add(1'b1, 2'd3, 1'b0, 1'b0, 8'd0, 1'b0, 2'd1, 8'd0, 8'd4, 8'd0, 8'd4);
    add(1'b1, 2'd3, 1'b1, 1'b0, 8'd0, 1'b0, 2'd1, 8'd0, 8'd4, 8'd0, 8'd4);
    add(1'b1, 2'd3, 1'b0, 1'b1, 8'd7, 1'b1, 2'd1, 8'd0, 8'd4, 8'd0, 8'd4);
    add(1'b0, 2'd1, 1'b0, 1'b0, 8'd0, 1'b0, 2'd3, 8'd0, 8'd4, 8'd0, 8'd0);
    add(1'b1, 2'd1, 1'b0, 1'b0, 8'd0, 1'b0, 2'd1, 8'd0, 8'd5, 8'd0, 8'd4);
    add(1'b1, 2'd2, 1'b0, 1'b0, 8'd0, 1'b0, 2'd2, 8'd0, 8'd5, 8'd1, 8'd0);
    add(1'b0, 2'd2, 1'b0, 1'b0, 8'd0, 1'b0, 2'd2, 8'd0, 8'd5, 8'd1, 8'd1);

    foreach (tv[i]) begin
      drive(tv[i].en, tv[i].sel, tv[i].clr, tv[i].we, tv[i].div, tv[i].sat, tv[i].rd);
      cycle();
      chk($sformatf("vec%0d_count0", i), 64'(Count_all[7:0]), 64'(tv[i].c0));
      chk($sformatf("vec%0d_count1", i), 64'(Count_all[15:8]), 64'(tv[i].c1));
      chk($sformatf("vec%0d_count2", i), 64'(Count_all[23:16]), 64'(tv[i].c2));
      chk($sformatf("vec%0d_ovf", i), 64'(Ovf), 64'(tv[i].ovf));
      chk($sformatf("vec%0d_rd_count", i), 64'(Rd_count), 64'(tv[i].rdc));
      chk($sformatf("vec%0d_rd_ovf", i), 64'(Rd_ovf), 64'd0);
    end

    // Wrap mode on channel 0
    drive(1'b1, 2'd0, 1'b0, 1'b0, 8'd0, 1'b0, 2'd0);
    for (int k = 0; k < 255; k++) cycle();
    chk("wrap_pre_count0", 64'(Count_all[7:0]), 64'd255);
    chk("wrap_pre_ovf", 64'(Ovf), 64'd0);
    cycle();
    chk("wrap_count0", 64'(Count_all[7:0]), 64'd0);
    chk("wrap_ovf", 64'(Ovf), 64'b001);
    for (int k = 0; k < 3; k++) cycle();
    chk("wrap_after_count0", 64'(Count_all[7:0]), 64'd3);
    chk("wrap_after_ovf", 64'(Ovf), 64'b001);
    drive(1'b0, 2'd0, 1'b0, 1'b0, 8'd0, 1'b0, 2'd0);
    cycle();
    chk("wrap_rd_ovf", 64'(Rd_ovf), 64'd1);
    chk("wrap_rd_count", 64'(Rd_count), 64'd3);

    // Saturate mode on channel 0
    drive(1'b0, 2'd0, 1'b1, 1'b0, 8'd0, 1'b0, 2'd0);
    cycle();
    chk("clr0_count0", 64'(Count_all[7:0]), 64'd0);
    chk("clr0_ovf", 64'(Ovf), 64'd0);
    drive(1'b0, 2'd0, 1'b0, 1'b1, 8'd1, 1'b1, 2'd0);
    cycle();
    drive(1'b1, 2'd0, 1'b0, 1'b0, 8'd0, 1'b0, 2'd0);
    for (int k = 0; k < 255; k++) cycle();
    chk("sat_pre_count0", 64'(Count_all[7:0]), 64'd255);
    chk("sat_pre_ovf", 64'(Ovf), 64'd0);
    cycle();
    chk("sat_count0", 64'(Count_all[7:0]), 64'd255);
    chk("sat_ovf", 64'(Ovf), 64'b001);
    drive(1'b0, 2'd0, 1'b1, 1'b0, 8'd0, 1'b0, 2'd0);
    cycle();
    chk("sat_clr_count0", 64'(Count_all[7:0]), 64'd0);
    chk("sat_clr_ovf", 64'(Ovf), 64'd0);
    drive(1'b1, 2'd0, 1'b0, 1'b0, 8'd0, 1'b0, 2'd0);
    for (int k = 0; k < 256; k++) cycle();
    chk("sat_kept_count0", 64'(Count_all[7:0]), 64'd255);
    chk("sat_kept_ovf", 64'(Ovf), 64'b001);

    // Mid-prescale asynchronous reset on channel 1
    drive(1'b0, 2'd1, 1'b0, 1'b1, 8'd4, 1'b0, 2'd1);
    cycle();
    drive(1'b1, 2'd1, 1'b0, 1'b0, 8'd0, 1'b0, 2'd1);
    cycle();
    cycle();
    chk("pre_rst_count1", 64'(Count_all[15:8]), 64'd5);
    drive(1'b0, 2'd1, 1'b0, 1'b0, 8'd0, 1'b0, 2'd1);
    Reset_n = 1'b0;
    #1;
    chk("rst_count_all", 64'(Count_all), 64'd0);
    chk("rst_ovf", 64'(Ovf), 64'd0);
    chk("rst_rd_count", 64'(Rd_count), 64'd0);
    chk("rst_rd_ovf", 64'(Rd_ovf), 64'd0);
    #2;
    Reset_n = 1'b1;
    drive(1'b1, 2'd1, 1'b0, 1'b0, 8'd0, 1'b0, 2'd1);
    cycle();
    chk("post_rst_count1_a", 64'(Count_all[15:8]), 64'd1);
    chk("post_rst_rd_a", 64'(Rd_count), 64'd0);
    cycle();
    chk("post_rst_count1_b", 64'(Count_all[15:8]), 64'd2);
    chk("post_rst_rd_b", 64'(Rd_count), 64'd1);
    chk("post_rst_count0", 64'(Count_all[7:0]), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
